// File: rtl/matrix_result_streamer_if.sv
// Result-stream and BRAM read-port bundle for matrix_result_streamer.
// master: the streamer (drives reads and out_*); slave: BRAM/formatter side.
interface matrix_result_streamer_if #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 10
);
    logic                     mem_rd_en;
    logic [ADDR_WIDTH-1:0]    mem_rd_addr;
    logic [ELEMENT_WIDTH-1:0] mem_rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [ELEMENT_WIDTH-1:0] out_data;
    logic [3:0]               out_row;
    logic [3:0]               out_col;
    logic                     out_eol;
    logic                     out_last;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_row,
        output out_col,
        output out_eol,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_eol,
        input  out_last
    );
endinterface

// File: rtl/matrix_result_streamer.sv
// Reads an m x n result matrix from BRAM in row-major order and streams it.
// Ports: clk/rst, start/busy/done/err_dim, dim_m/dim_n/addr_base, bus (master).
module matrix_result_streamer #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int RD_LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err_dim,
    input  logic [3:0]            dim_m,
    input  logic [3:0]            dim_n,
    input  logic [ADDR_WIDTH-1:0] addr_base,
    matrix_result_streamer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAP,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    state_t                   state_q, state_d;
    logic [3:0]               i_q, i_d;
    logic [3:0]               j_q, j_d;
    logic [3:0]               m_q, m_d;
    logic [3:0]               n_q, n_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic                     valid_q, valid_d;
    logic [ELEMENT_WIDTH-1:0] data_q, data_d;
    logic [3:0]               row_q, row_d;
    logic [3:0]               col_q, col_d;
    logic                     eol_q, eol_d;
    logic                     last_q, last_d;

    logic                     row_end;
    logic                     mat_end;
    logic [ADDR_WIDTH-1:0]    addr_calc;

    assign row_end = (j_q == n_q - 4'd1);
    assign mat_end = row_end && (i_q == m_q - 4'd1);

    // Row-major offset; overflow past the top of BRAM wraps silently.
    assign addr_calc = base_q
                     + (ADDR_WIDTH'(i_q) * ADDR_WIDTH'(n_q))
                     + ADDR_WIDTH'(j_q);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        m_d       = m_q;
        n_d       = n_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        row_d     = row_q;
        col_d     = col_q;
        eol_d     = eol_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d    = dim_m;
                    n_d    = dim_n;
                    base_d = addr_base;
                    i_d    = 4'd0;
                    j_d    = 4'd0;
                    if (dim_m == 4'd0 || dim_n == 4'd0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                rd_en_d   = 1'b1;
                rd_addr_d = addr_calc;
                cnt_d     = 3'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                rd_en_d = 1'b0;
                if (cnt_q == LAT_LAST) begin
                    state_d = S_CAP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_CAP: begin
                data_d  = bus.mem_rd_data;
                row_d   = i_q;
                col_d   = j_q;
                eol_d   = row_end;
                last_d  = mat_end;
                valid_d = 1'b1;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (row_end) begin
                        j_d = 4'd0;
                        if (mat_end) begin
                            state_d = S_DONE;
                        end else begin
                            i_d     = i_q + 4'd1;
                            state_d = S_ISSUE;
                        end
                    end else begin
                        j_d     = j_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            m_q       <= '0;
            n_q       <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            eol_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            m_q       <= m_d;
            n_q       <= n_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            row_q     <= row_d;
            col_q     <= col_d;
            eol_q     <= eol_d;
            last_q    <= last_d;
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign err_dim = err_q;

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.out_row     = row_q;
    assign bus.out_col     = col_q;
    assign bus.out_eol     = eol_q;
    assign bus.out_last    = last_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer with a BRAM model.
// BRAM word at address a holds (a - 15) mod 256, so 0x010..0x015 hold 1..6.
module tb_matrix_result_streamer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       err_dim;
    logic [3:0] dim_m;
    logic [3:0] dim_n;
    logic [9:0] addr_base;

    int errors = 0;
    int checks = 0;
    int ticks;
    int rd_base;
    int vc0;

    logic [7:0] mem [0:1023];
    logic [9:0] rd_log [$];
    int         vcnt = 0;

    matrix_result_streamer_if #(.ELEMENT_WIDTH(8), .ADDR_WIDTH(10)) bus ();

    matrix_result_streamer #(
        .ELEMENT_WIDTH(8),
        .ADDR_WIDTH(10),
        .RD_LATENCY(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err_dim   (err_dim),
        .dim_m     (dim_m),
        .dim_n     (dim_n),
        .addr_base (addr_base),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    always @(negedge clk) begin
        if (bus.mem_rd_en) rd_log.push_back(bus.mem_rd_addr);
        if (bus.out_valid) vcnt <= vcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word_at(input int a);
        return 8'((a % 1024) - 15);
    endfunction

    // Streams one matrix, checking timing, payload, tags and read order.
    task automatic run_matrix(input string tag, input int m, input int n,
                              input int base, input int stall_k,
                              input int stall_len, input bit hold_start,
                              input int pulse_k, output int t);
        int w;
        logic [7:0] d;
        logic [3:0] r, c;
        rd_base   = rd_log.size();
        dim_m     = 4'(m);
        dim_n     = 4'(n);
        addr_base = 10'(base);
        out_ready_set(1'b1);
        start     = 1'b1;
        tick();
        t = 0;
        if (!hold_start) start = 1'b0;
        dim_m     = 4'hF;
        dim_n     = 4'hF;
        addr_base = 10'h3FF;
        check({tag, "_busy0"}, busy, 1);
        check({tag, "_rden0"}, bus.mem_rd_en, 0);
        for (int k = 0; k < m * n; k++) begin
            if (k == stall_k) out_ready_set(1'b0);
            if (k == pulse_k) start = 1'b1;
            w = 0;
            if (k == 0) begin
                tick();
                w++;
                t++;
                check({tag, "_rden1"}, bus.mem_rd_en, 1);
                check({tag, "_addr1"}, bus.mem_rd_addr, base % 1024);
            end
            while (!bus.out_valid && w < 20) begin
                tick();
                w++;
                t++;
                if (!hold_start) start = 1'b0;
            end
            r = 4'(k / n);
            c = 4'(k % n);
            d = word_at(base + k);
            check({tag, "_lat"}, w, 4);
            check({tag, "_data"}, bus.out_data, d);
            check({tag, "_row"}, bus.out_row, r);
            check({tag, "_col"}, bus.out_col, c);
            check({tag, "_eol"}, bus.out_eol, (k % n) == n - 1);
            check({tag, "_last"}, bus.out_last, k == m * n - 1);
            check({tag, "_done_mid"}, done, 0);
            if (k == stall_k) begin
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    t++;
                    check({tag, "_hold_v"}, bus.out_valid, 1);
                    check({tag, "_hold_d"}, bus.out_data, d);
                    check({tag, "_hold_r"}, bus.out_row, r);
                    check({tag, "_hold_c"}, bus.out_col, c);
                    check({tag, "_hold_rd"}, rd_log.size(), rd_base + k + 1);
                end
                out_ready_set(1'b1);
            end
            tick();
            t++;
            check({tag, "_vdrop"}, bus.out_valid, 0);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_err"}, err_dim, 0);
        check({tag, "_nrd"}, rd_log.size(), rd_base + m * n);
        for (int k = 0; k < m * n && rd_base + k < rd_log.size(); k++)
            check({tag, "_rdaddr"}, rd_log[rd_base + k], (base + k) % 1024);
        if (!hold_start) begin
            tick();
            check({tag, "_idle"}, done, 0);
        end
    endtask

    task automatic out_ready_set(input logic v);
        bus.out_ready = v;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = word_at(a);
        rst       = 1'b1;
        start     = 1'b0;
        dim_m     = 4'd0;
        dim_n     = 4'd0;
        addr_base = 10'd0;
        out_ready_set(1'b0);
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_dim, 0);
        check("rst_rden", bus.mem_rd_en, 0);
        check("rst_addr", bus.mem_rd_addr, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_row", bus.out_row, 0);
        check("rst_col", bus.out_col, 0);
        check("rst_eol", bus.out_eol, 0);
        check("rst_last", bus.out_last, 0);
        rst = 1'b0;
        out_ready_set(1'b1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_rden", bus.mem_rd_en, 0);

        run_matrix("t1", 2, 3, 16, -1, 0, 1'b0, -1, ticks);
        check("t1_ticks", ticks, 30);

        run_matrix("t2", 2, 3, 16, 1, 7, 1'b0, -1, ticks);
        check("t2_ticks", ticks, 37);

        rd_base   = rd_log.size();
        vc0       = vcnt;
        dim_m     = 4'd0;
        dim_n     = 4'd4;
        addr_base = 10'h010;
        start     = 1'b1;
        tick();
        check("t3_done", done, 1);
        check("t3_err", err_dim, 1);
        check("t3_busy", busy, 0);
        start = 1'b0;
        tick();
        check("t3_idle", done, 0);
        check("t3_err_hold", err_dim, 1);
        tick();
        check("t3_nrd", rd_log.size(), rd_base);
        check("t3_nvalid", vcnt, vc0);

        run_matrix("t4", 15, 15, 1014, -1, 0, 1'b0, -1, ticks);
        check("t4_ticks", ticks, 1125);
        check("t4_err_clr", err_dim, 0);
        check("t4_wrap10", rd_log[rd_base + 10], 0);
        check("t4_wrap224", rd_log[rd_base + 224], 214);

        dim_m     = 4'd2;
        dim_n     = 4'd3;
        addr_base = 10'h010;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 20 && !bus.out_valid; w++) tick();
            check("t5_data", bus.out_data, k + 1);
            if (k < 2) tick();
            if (k == 1) out_ready_set(1'b0);
        end
        tick();
        check("t5_hold", bus.out_valid, 1);
        rst = 1'b1;
        tick();
        check("t5_valid", bus.out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_data0", bus.out_data, 0);
        check("t5_col0", bus.out_col, 0);
        check("t5_eol0", bus.out_eol, 0);
        rst = 1'b0;
        out_ready_set(1'b1);
        tick();
        check("t5_idle", busy, 0);
        run_matrix("t5r", 2, 3, 16, -1, 0, 1'b0, -1, ticks);
        check("t5r_ticks", ticks, 30);

        run_matrix("t6", 1, 2, 16, -1, 0, 1'b1, -1, ticks);
        check("t6_ticks", ticks, 10);
        rd_base = rd_log.size();
        repeat (3) begin
            tick();
            check("t6_done_hold", done, 1);
            check("t6_busy", busy, 0);
        end
        check("t6_norestart", rd_log.size(), rd_base);
        start = 1'b0;
        tick();
        check("t6_idle", done, 0);
        tick();
        check("t6_idle_busy", busy, 0);

        run_matrix("t7", 2, 3, 16, -1, 0, 1'b0, 2, ticks);
        check("t7_ticks", ticks, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Downstream consumer of the matrix op units: once an op (e.g. add) has written its result matrix into BRAM, this block reads it back element by element in row-major order.
- It presents each element on a valid/ready stream toward the display/UART formatter, with row/column tags and row-end/last markers.
- BRAM read timing matches the op units: registered one-cycle read strobe, then a fixed wait before sampling.

Parameters:
- ELEMENT_WIDTH, 8: width of one stored element.
- ADDR_WIDTH, 10: BRAM address width.
- RD_LATENCY, 2: wait cycles between the strobe cycle and the sample edge. Legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level request; accepted only in IDLE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE; held until start is low
- err_dim  out  1  set with done when a latched dimension is 0
- dim_m  in  4  rows (1..15)
- dim_n  in  4  columns (1..15)
- addr_base  in  ADDR_WIDTH  base address of the result matrix
- mem_rd_en  out  1  one-cycle read strobe
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_data  in  ELEMENT_WIDTH  BRAM read data
- out_valid  out  1  out_data/out_row/out_col/out_eol/out_last are valid
- out_ready  in  1  downstream accepts the element
- out_data  out  ELEMENT_WIDTH  element value
- out_row  out  4  row index i
- out_col  out  4  column index j
- out_eol  out  1  j == n-1
- out_last  out  1  i == m-1 and j == n-1

Behaviour:
- Reset (sync, rst=1 at any edge, including mid-operation):
  - State goes to IDLE.
  - busy, done, err_dim, mem_rd_en, out_valid, out_eol and out_last go to 0.
  - out_data, out_row, out_col, mem_rd_addr and internal i, j, m, n, base go to 0.
  - Any partially presented element is dropped.
- States: IDLE, ISSUE, WAIT, CAP, PRESENT, DONE.
- IDLE:
  - On start=1: latch m=dim_m, n=dim_n, base=addr_base; clear i and j.
  - If m==0 or n==0: go to DONE with err_dim<=1; no reads are issued.
  - Otherwise go to ISSUE with err_dim<=0.
- Dimension inputs are ignored after latching; start is ignored while not in IDLE.
- ISSUE:
  - mem_rd_en<=1.
  - mem_rd_addr<=base + i*n + j, truncated to ADDR_WIDTH (wrap-around is silent).
  - Clear wait counter; go to WAIT.
- WAIT:
  - mem_rd_en<=0; the strobe is exactly one cycle wide.
  - Stay RD_LATENCY cycles, then go to CAP.
- CAP:
  - out_data<=mem_rd_data; out_row<=i; out_col<=j.
  - out_eol and out_last are set per the index conditions above.
  - out_valid<=1; go to PRESENT.
- PRESENT:
  - out_valid and all tags stay stable until an edge with out_ready=1.
  - At that edge: out_valid<=0 and indices advance.
  - If j==n-1: j<=0, then i<=i+1; if i==m-1, go to DONE instead.
  - Else j<=j+1. In both non-final cases go to ISSUE.
- DONE: done<=1; when start==0, go to IDLE and clear done. err_dim holds until the next accepted start.
- Timing (start sampled at edge 0, out_ready held high):
  - mem_rd_en high in the cycle after edge 1.
  - First out_valid after edge RD_LATENCY+2.
  - Element period RD_LATENCY+3 cycles.
  - done rises one edge after the final handshake.
- out_ready high outside PRESENT has no effect. out_valid never rises while out_ready is low-only gated; it is independent of out_ready.
- At most one BRAM read is outstanding. The block never writes memory.

Test Plan:
- 2x3 matrix at base 0x010 holding 1..6, out_ready=1 → reads at 0x010..0x015 in order; stream 1..6 with (row,col) (0,0)..(1,2); out_eol on elements 3 and 6; out_last only on 6; first out_valid 4 cycles after start edge; period 5 cycles; done 1 cycle after the 6th handshake.
- Same 2x3 matrix, out_ready low for 7 cycles on element 2 → out_valid/out_data=2/tags held stable; no new mem_rd_en until the handshake; total runtime extended by 7 cycles.
- dim_m=0, dim_n=4 → done=1 and err_dim=1 one edge after start; mem_rd_en and out_valid never assert.
- 15x15 at base 2^ADDR_WIDTH-10 → addresses wrap past 0 (element 10 at address 0); 225 elements streamed; out_last on (14,14).
- rst=1 during PRESENT of element 3 → next edge: out_valid=0, busy=0, IDLE. A new start replays from element (0,0).
- start held high through DONE → no restart; done stays 1. Start dropped → IDLE. Start pulsed while busy → ignored.
